ocram_arbiter_2p: RTL and testbench
===================================

# ocram_arbiter_2p

Two-port Avalon-MM arbiter that shares the single-port 8192 x 16 on-chip RAM between two masters (e.g. CPU data master and a DMA/peripheral master). Each cycle it selects at most one request, drives the RAM port combinationally, and returns read data one cycle later tagged to the owning master. It sits between the interconnect masters and the RAM's address/byteenable/chipselect/write/writedata/clken/readdata port.

## Interface
- ADDR_W, 13, RAM word-address width
- DATA_W, 16, data width
- BE_W, 2, byteenable width (DATA_W/8)

- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- m0_address / m1_address  in  ADDR_W  word address
- m0_byteenable / m1_byteenable  in  BE_W  byte lanes for writes
- m0_read / m1_read  in  1  read request
- m0_write / m1_write  in  1  write request
- m0_writedata / m1_writedata  in  DATA_W  write data
- m0_waitrequest / m1_waitrequest  out  1  high = request not accepted this cycle
- m0_readdata / m1_readdata  out  DATA_W  read data, valid only with readdatavalid
- m0_readdatavalid / m1_readdatavalid  out  1  read data valid pulse
- ram_address  out  ADDR_W; ram_byteenable  out  BE_W; ram_writedata  out  DATA_W
- ram_chipselect  out  1; ram_write  out  1; ram_clken  out  1
- ram_readdata  in  DATA_W  RAM q, valid the cycle after the address is clocked

## Operation
- Request: mX_req = mX_read | mX_write. Read and write both high: write wins, read ignored (illegal master behaviour, no error flagged).
- Ready register rdy: 0 in reset, 1 on first clk edge after reset deasserts. While rdy=0: both waitrequest=1, ram_chipselect=0, ram_write=0, ram_clken=0.
- Grant (combinational, rdy=1): one requester -> it is granted. Both -> per arbitration policy (see Configuration). None -> ram_chipselect=0, ram_write=0, address/writedata/byteenable hold last granted values.
- Granted master: waitrequest=0; its address, byteenable, writedata copied to ram_*; ram_chipselect=1; ram_write=its write. Loser: waitrequest=1, must hold its request stable.
- Reads issue with ram_byteenable forced to all ones.
- last_grant register (1 bit): updated to granted index on every accepted transfer; reset value 1 (so m0 wins the first contention).
- Read return: rd_pend (1 bit) and rd_owner (1 bit) registered on an accepted read; next cycle mOwner_readdatavalid=1, other master's =0. mX_readdata = ram_readdata for both masters (broadcast, qualified by valid).
- ram_clken = rdy.

## Timing
- Reset values: rdy=0, last_grant=1, rd_pend=0, rd_owner=0; both readdatavalid=0, both waitrequest=1, ram_chipselect=0, ram_write=0, ram_clken=0, ram_address/byteenable/writedata=0.
- waitrequest: same-cycle combinational response to requests.
- Write: completes on the accepting edge; zero wait states if uncontended.
- Read latency: exactly 1 cycle from accepting edge to readdatavalid; fully pipelined, throughput 1 access/cycle, back-to-back reads from alternating masters each return in order.
- Read followed by write (same or other master) next cycle: allowed; readdatavalid of the read still occurs in that cycle.
- Reset asserted mid-read: pending readdatavalid is dropped (never emitted); no RAM access until rdy returns to 1.

## Configuration
- OCRAM_ARB_ROUND_ROBIN_EN defined: on contention grant the master opposite last_grant; each of two continuously-requesting masters receives every other cycle.
- Not defined: fixed priority, m0 always wins contention; last_grant still maintained but unused for selection; m1 may starve.

## Test plan
- Reset release: assert reset, both masters read -> waitrequest=1, chipselect=0 until first edge after release; first contention grants m0.
- Single-master write/read: m0 writes 0xBEEF to 0x0010 (be=2'b11), then reads 0x0010 -> m0_readdatavalid one cycle later with 0xBEEF, m1_readdatavalid stays 0.
- Byte write: m1 writes 0x12AB to 0x1FFF with be=2'b01 over prior 0xFFFF -> read returns 0xFFAB.
- Contention, RR build: both masters read continuously for 8 cycles -> grants m0,m1,m0,m1...; each gets 4 readdatavalid pulses, correct data per owner.
- Contention, fixed build: same stimulus -> m0 granted all 8 cycles, m1_waitrequest held 1.
- Reset mid-read: accept m1 read, assert reset before next edge -> no m1_readdatavalid, all outputs at reset values.

Source files
------------

// File: rtl/ocram_arbiter_2p.sv
// ocram_arbiter_2p: shares a single-port 8192 x 16 on-chip RAM between two
// Avalon-MM masters. One access per cycle is granted combinationally; read
// data returns one cycle later, tagged to the master that issued the read.
// Optional feature macro: OCRAM_ARB_ROUND_ROBIN_EN (round-robin on contention;
// when undefined m0 has fixed priority).
module ocram_arbiter_2p #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 16,
  parameter int BE_W   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] ram_address,
  output logic [BE_W-1:0]   ram_byteenable,
  output logic [DATA_W-1:0] ram_writedata,
  output logic              ram_chipselect,
  output logic              ram_write,
  output logic              ram_clken,
  input  logic [DATA_W-1:0] ram_readdata
);

  logic              rdy;
  logic              last_grant;
  logic              rd_pend;
  logic              rd_owner;
  logic [ADDR_W-1:0] hold_address;
  logic [BE_W-1:0]   hold_byteenable;
  logic [DATA_W-1:0] hold_writedata;

  logic              req0;
  logic              req1;
  logic              prefer_m1;
  logic              grant0;
  logic              grant1;
  logic              accept;
  logic              sel_write;
  logic [ADDR_W-1:0] sel_address;
  logic [BE_W-1:0]   sel_byteenable;
  logic [DATA_W-1:0] sel_writedata;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

`ifdef OCRAM_ARB_ROUND_ROBIN_EN
  // On contention the master that did not win last time goes first.
  assign prefer_m1 = ~last_grant;
`else
  // Fixed priority: m0 always wins; last_grant is still tracked but never steers.
  assign prefer_m1 = last_grant & 1'b0;
`endif

  // Grant selection and RAM port drive; nothing is granted until rdy.
  always_comb begin
    grant0         = 1'b0;
    grant1         = 1'b0;
    if (rdy) begin
      if (req0 && req1) begin
        grant1 = prefer_m1;
        grant0 = ~prefer_m1;
      end else begin
        grant0 = req0;
        grant1 = req1;
      end
    end
    accept         = grant0 | grant1;
    sel_write      = grant1 ? m1_write : m0_write;
    sel_address    = grant1 ? m1_address : m0_address;
    sel_writedata  = grant1 ? m1_writedata : m0_writedata;
    // Reads always fetch the full word; byte lanes only matter for writes.
    sel_byteenable = sel_write ? (grant1 ? m1_byteenable : m0_byteenable) : {BE_W{1'b1}};

    ram_address    = accept ? sel_address    : hold_address;
    ram_byteenable = accept ? sel_byteenable : hold_byteenable;
    ram_writedata  = accept ? sel_writedata  : hold_writedata;
    ram_chipselect = accept;
    ram_write      = accept & sel_write;
    ram_clken      = rdy;

    m0_waitrequest = ~grant0;
    m1_waitrequest = ~grant1;
  end

  // Control state: ready flag, arbitration history and read-return tracking.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdy        <= 1'b0;
      last_grant <= 1'b1;
      rd_pend    <= 1'b0;
      rd_owner   <= 1'b0;
    end else begin
      rdy     <= 1'b1;
      rd_pend <= accept & ~sel_write;
      if (accept) begin
        last_grant <= grant1;
      end
      if (accept && !sel_write) begin
        rd_owner <= grant1;
      end
    end
  end

  // RAM port values held while idle so the address bus does not toggle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_address    <= '0;
      hold_byteenable <= '0;
      hold_writedata  <= '0;
    end else if (accept) begin
      hold_address    <= sel_address;
      hold_byteenable <= sel_byteenable;
      hold_writedata  <= sel_writedata;
    end
  end

  // Read data is broadcast; only the owner's valid strobe qualifies it.
  always_comb begin
    m0_readdata      = ram_readdata;
    m1_readdata      = ram_readdata;
    m0_readdatavalid = rd_pend & ~rd_owner;
    m1_readdatavalid = rd_pend &  rd_owner;
  end

endmodule

// File: tb/tb_ocram_arbiter_2p.sv
// Directed testbench for ocram_arbiter_2p with a behavioural RAM model.
module tb_ocram_arbiter_2p;

  localparam int ADDR_W = 13;
  localparam int DATA_W = 16;
  localparam int BE_W   = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [ADDR_W-1:0] m0_address, m1_address;
  logic [BE_W-1:0]   m0_byteenable, m1_byteenable;
  logic              m0_read, m0_write, m1_read, m1_write;
  logic [DATA_W-1:0] m0_writedata, m1_writedata;
  logic              m0_waitrequest, m1_waitrequest;
  logic [DATA_W-1:0] m0_readdata, m1_readdata;
  logic              m0_readdatavalid, m1_readdatavalid;
  logic [ADDR_W-1:0] ram_address;
  logic [BE_W-1:0]   ram_byteenable;
  logic [DATA_W-1:0] ram_writedata;
  logic              ram_chipselect, ram_write, ram_clken;
  logic [DATA_W-1:0] ram_readdata;

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  int checks   = 0;
  int failures = 0;
  int cnt0;
  int cnt1;
  logic exp1;
  logic rr_build;

  always #5 clk = ~clk;

  ocram_arbiter_2p #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W)) dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .ram_address(ram_address), .ram_byteenable(ram_byteenable),
    .ram_writedata(ram_writedata), .ram_chipselect(ram_chipselect),
    .ram_write(ram_write), .ram_clken(ram_clken), .ram_readdata(ram_readdata)
  );

  // Single-port RAM with byte enables and registered read data.
  always @(posedge clk) begin
    if (ram_clken && ram_chipselect) begin
      if (ram_write) begin
        if (ram_byteenable[0]) mem[ram_address][7:0]  <= ram_writedata[7:0];
        if (ram_byteenable[1]) mem[ram_address][15:8] <= ram_writedata[15:8];
      end
      ram_readdata <= mem[ram_address];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    m0_read = 1'b0; m0_write = 1'b0;
    m1_read = 1'b0; m1_write = 1'b0;
  endtask

  task automatic wr(input logic port, input logic [ADDR_W-1:0] a,
                    input logic [DATA_W-1:0] d, input logic [BE_W-1:0] be);
    idle();
    if (port) begin
      m1_address = a; m1_writedata = d; m1_byteenable = be; m1_write = 1'b1;
    end else begin
      m0_address = a; m0_writedata = d; m0_byteenable = be; m0_write = 1'b1;
    end
    tick();
    idle();
  endtask

  initial begin
`ifdef OCRAM_ARB_ROUND_ROBIN_EN
    rr_build = 1'b1;
`else
    rr_build = 1'b0;
`endif
    reset = 1'b1;
    m0_address = 13'h0005; m1_address = 13'h0006;
    m0_byteenable = 2'b00; m1_byteenable = 2'b00;
    m0_writedata = '0; m1_writedata = '0;
    m0_write = 1'b0; m1_write = 1'b0;
    m0_read = 1'b1; m1_read = 1'b1;
    tick(); tick();
    #1;
    chk("rst_m0_wait", m0_waitrequest, 1);
    chk("rst_m1_wait", m1_waitrequest, 1);
    chk("rst_cs", ram_chipselect, 0);
    chk("rst_clken", ram_clken, 0);
    chk("rst_rdv", {m0_readdatavalid, m1_readdatavalid}, 0);
    chk("rst_addr", ram_address, 0);

    // Release reset: still not ready until the next edge.
    reset = 1'b0;
    #1;
    chk("pre_rdy_m0_wait", m0_waitrequest, 1);
    chk("pre_rdy_cs", ram_chipselect, 0);
    tick(); #1;
    chk("first_cont_m0_wait", m0_waitrequest, 0);
    chk("first_cont_m1_wait", m1_waitrequest, 1);
    chk("first_cont_cs", ram_chipselect, 1);
    chk("first_cont_addr", ram_address, 13'h0005);
    chk("rdy_clken", ram_clken, 1);
    tick();
    idle();
    #1;
    chk("first_rdv_m0", m0_readdatavalid, 1);
    chk("first_rdv_m1", m1_readdatavalid, 0);
    chk("idle_cs", ram_chipselect, 0);
    chk("idle_hold_addr", ram_address, 13'h0005);

    // m0 full-word write then read back.
    idle();
    m0_address = 13'h0010; m0_writedata = 16'hBEEF; m0_byteenable = 2'b11; m0_write = 1'b1;
    #1;
    chk("wr_m0_wait", m0_waitrequest, 0);
    chk("wr_ram_write", ram_write, 1);
    chk("wr_ram_wdata", ram_writedata, 16'hBEEF);
    tick();
    idle();
    m0_address = 13'h0010; m0_byteenable = 2'b00; m0_read = 1'b1;
    #1;
    chk("rd_be_forced", ram_byteenable, 2'b11);
    chk("rd_ram_write", ram_write, 0);
    tick();
    idle();
    #1;
    chk("rd_m0_rdv", m0_readdatavalid, 1);
    chk("rd_m1_rdv", m1_readdatavalid, 0);
    chk("rd_m0_data", m0_readdata, 16'hBEEF);

    // m1 byte write over 0xFFFF.
    wr(1'b1, 13'h1FFF, 16'hFFFF, 2'b11);
    wr(1'b1, 13'h1FFF, 16'h12AB, 2'b01);
    m1_address = 13'h1FFF; m1_byteenable = 2'b01; m1_read = 1'b1;
    #1;
    chk("bw_rd_be", ram_byteenable, 2'b11);
    tick();
    idle();
    #1;
    chk("bw_m1_rdv", m1_readdatavalid, 1);
    chk("bw_m0_rdv", m0_readdatavalid, 0);
    chk("bw_m1_data", m1_readdata, 16'hFFAB);

    // Read and write both high: write wins, no read return.
    m0_address = 13'h0020; m0_writedata = 16'h5A5A; m0_byteenable = 2'b11;
    m0_write = 1'b1; m0_read = 1'b1;
    #1;
    chk("rw_both_write", ram_write, 1);
    tick();
    idle();
    #1;
    chk("rw_both_no_rdv", m0_readdatavalid, 0);

    // Contention: both read continuously for 8 cycles (last grant was m1).
    wr(1'b0, 13'h0100, 16'h1111, 2'b11);
    wr(1'b1, 13'h0200, 16'h2222, 2'b11);
    m0_address = 13'h0100; m1_address = 13'h0200;
    m0_read = 1'b1; m1_read = 1'b1;
    cnt0 = 0; cnt1 = 0;
    for (int i = 0; i < 8; i++) begin
      exp1 = rr_build & (i % 2 == 1);
      #1;
      chk("cont_m0_wait", m0_waitrequest, exp1);
      chk("cont_m1_wait", m1_waitrequest, !exp1);
      tick();
      if (i == 7) idle();
      #1;
      chk("cont_m0_rdv", m0_readdatavalid, !exp1);
      chk("cont_m1_rdv", m1_readdatavalid, exp1);
      chk("cont_data", exp1 ? m1_readdata : m0_readdata, exp1 ? 16'h2222 : 16'h1111);
      if (m0_readdatavalid) cnt0++;
      if (m1_readdatavalid) cnt1++;
    end
    chk("cont_cnt0", cnt0, rr_build ? 4 : 8);
    chk("cont_cnt1", cnt1, rr_build ? 4 : 0);

    // Reset mid-read: the pending m1 return must be dropped.
    m1_address = 13'h0200; m1_read = 1'b1;
    #1;
    chk("mid_m1_wait", m1_waitrequest, 0);
    tick();
    reset = 1'b1;
    idle();
    #1;
    chk("mid_m1_rdv", m1_readdatavalid, 0);
    chk("mid_m0_rdv", m0_readdatavalid, 0);
    chk("mid_waits", {m0_waitrequest, m1_waitrequest}, 2'b11);
    chk("mid_cs_wr_clk", {ram_chipselect, ram_write, ram_clken}, 3'b000);
    chk("mid_addr", ram_address, 0);
    chk("mid_be", ram_byteenable, 0);
    chk("mid_wdata", ram_writedata, 0);
    tick();
    #1;
    chk("mid_rdv_after_edge", m1_readdatavalid, 0);
    reset = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
